// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and defaults for the SDRAM bridge port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  typedef enum logic [1:0] {CL_INIT, CL_I2S, CL_VID} arb_client_t;

  localparam int DEF_TIMEOUT_CYC = 1023;
  localparam int DEF_ADDR_W      = 25;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bridge-side bus between the arbiter (master) and the SDRAM controller bridge (slave).
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = sdram_arb_pkg::DEF_ADDR_W
);
  logic [ADDR_W-1:0] ar_addr;
  logic [1:0]        ar_be;
  logic              ar_read;
  logic              ar_write;
  logic [15:0]       ar_wrdata;
  logic              ar_ac;
  logic [15:0]       ar_rddata;

  modport master (
    output ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
    input  ar_ac, ar_rddata
  );

  modport slave (
    input  ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
    output ar_ac, ar_rddata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-client SDRAM bridge arbiter: loader-exclusive until init_done, then I2S over video.
// One bridge transaction at a time; stalled accesses are aborted by a watchdog counter.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.master ar,
  input  logic                 init_we,
  input  logic [ADDR_W-1:0]    init_addr,
  input  logic [15:0]          init_wrdata,
  input  logic                 init_done,
  output logic                 init_ac,
  input  logic                 i2s_rd,
  input  logic [ADDR_W-1:0]    i2s_addr,
  output logic [15:0]          i2s_data,
  output logic                 i2s_ac,
  output logic                 i2s_wait,
  input  logic                 vid_rd,
  input  logic [ADDR_W-1:0]    vid_addr,
  output logic [15:0]          vid_data,
  output logic                 vid_ac,
  output logic                 bus_err
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        state_q, state_d;
  arb_client_t       grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wrdata_q, wrdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       i2s_data_q, i2s_data_d;
  logic [15:0]       vid_data_q, vid_data_d;
  logic              init_ac_q, init_ac_d;
  logic              i2s_ac_q, i2s_ac_d;
  logic              vid_ac_q, vid_ac_d;
  logic              bus_err_q, bus_err_d;
  logic [15:0]       rdata_sel;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    read_d     = read_q;
    write_d    = write_q;
    cnt_d      = cnt_q;
    i2s_data_d = i2s_data_q;
    vid_data_d = vid_data_q;
    init_ac_d  = 1'b0;
    i2s_ac_d   = 1'b0;
    vid_ac_d   = 1'b0;
    bus_err_d  = bus_err_q;
    rdata_sel  = ar.ar_ac ? ar.ar_rddata : 16'h0000;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Until loading completes the loader owns the bus outright.
        if (!init_done) begin
          if (init_we) begin
            grant_d  = CL_INIT;
            addr_d   = init_addr;
            wrdata_d = init_wrdata;
            write_d  = 1'b1;
            state_d  = BUSY;
          end
        end else if (i2s_rd) begin
          grant_d = CL_I2S;
          addr_d  = i2s_addr;
          read_d  = 1'b1;
          state_d = BUSY;
        end else if (vid_rd) begin
          grant_d = CL_VID;
          addr_d  = vid_addr;
          read_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A timed-out access still completes towards the client, with zero data.
        if (ar.ar_ac || cnt_q == CNT_LAST) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = GAP;
          if (!ar.ar_ac) bus_err_d = 1'b1;
          case (grant_q)
            CL_INIT: init_ac_d = 1'b1;
            CL_I2S: begin
              i2s_ac_d   = 1'b1;
              i2s_data_d = rdata_sel;
            end
            default: begin
              vid_ac_d   = 1'b1;
              vid_data_d = rdata_sel;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= CL_INIT;
      addr_q     <= '0;
      wrdata_q   <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      cnt_q      <= '0;
      i2s_data_q <= '0;
      vid_data_q <= '0;
      init_ac_q  <= 1'b0;
      i2s_ac_q   <= 1'b0;
      vid_ac_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      read_q     <= read_d;
      write_q    <= write_d;
      cnt_q      <= cnt_d;
      i2s_data_q <= i2s_data_d;
      vid_data_q <= vid_data_d;
      init_ac_q  <= init_ac_d;
      i2s_ac_q   <= i2s_ac_d;
      vid_ac_q   <= vid_ac_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign ar.ar_addr   = addr_q;
  assign ar.ar_be     = 2'b11;
  assign ar.ar_read   = read_q;
  assign ar.ar_write  = write_q;
  assign ar.ar_wrdata = wrdata_q;

  assign init_ac  = init_ac_q;
  assign i2s_ac   = i2s_ac_q;
  assign vid_ac   = vid_ac_q;
  assign i2s_data = i2s_data_q;
  assign vid_data = vid_data_q;
  assign bus_err  = bus_err_q;
  assign i2s_wait = i2s_rd & ~(state_q == BUSY && grant_q == CL_I2S);

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Three-client arbiter between the SDRAM controller's external bus bridge and its masters: the SD-card loader (write-only), the I2S audio fetcher (read-only) and the video line fetcher (read-only). Only one bridge transaction is outstanding at a time. The SD loader has exclusive access until loading completes; after that, I2S has fixed priority over video so audio never underruns. Bridge timeouts are detected and flagged.

## Interface
- TIMEOUT_CYC, 1023, cycles without bridge acknowledge before a transaction is aborted
- ADDR_W, 25, word-address width
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- ar_addr  out  ADDR_W  bridge word address (byte address is {ar_addr,1'b0} at the controller)
- ar_be  out  2  byte enables
- ar_read, ar_write  out  1  bridge strobes, held until ar_ac
- ar_wrdata  out  16  bridge write data
- ar_ac  in  1  bridge acknowledge, one-cycle pulse
- ar_rddata  in  16  bridge read data, valid with ar_ac
- init_we  in  1  SD loader write request
- init_addr  in  ADDR_W  loader address
- init_wrdata  in  16  loader data
- init_done  in  1  loader finished (level)
- init_ac  out  1  loader acknowledge pulse
- i2s_rd  in  1  audio read request
- i2s_addr  in  ADDR_W  audio address
- i2s_data  out  16  audio read data, registered
- i2s_ac  out  1  audio acknowledge pulse
- i2s_wait  out  1  audio request pending, not granted
- vid_rd  in  1  video read request
- vid_addr  in  ADDR_W  video address
- vid_data  out  16  video read data, registered
- vid_ac  out  1  video acknowledge pulse
- bus_err  out  1  sticky timeout flag

## Operation
- States: IDLE, BUSY, GAP.
- IDLE:
  - If !init_done, only init_we is eligible.
  - If init_done, priority is i2s_rd > vid_rd; init_we is ignored.
  - On a grant: latch the client ID, address and data into the bridge registers, set ar_read or ar_write, and go to BUSY.
- BUSY:
  - Bridge outputs are held constant.
  - On ar_ac: drop the strobes; for a read, capture ar_rddata into the granted client's data register; pulse that client's ac for one cycle; go to GAP.
  - Timeout counter reaches TIMEOUT_CYC-1: drop the strobes, set bus_err, pulse the client ac anyway (read data = 16'h0000), and go to GAP.
- GAP: one cycle with the strobes low, then IDLE. Clients drop or advance their request during this cycle.
- ar_be is always 2'b11.
- The address is zero-extended or truncated to ADDR_W; no arithmetic is performed.
- i2s_wait = i2s_rd & !(state==BUSY & grant==I2S), combinational.
- A request deasserted while BUSY does not cancel the transaction; ac still pulses.
- init_done rising while the loader is BUSY: the current write completes normally; the new policy applies from the next IDLE.
- ar_ac seen in IDLE or GAP is ignored (spurious).
- bus_err clears only on reset.

## Timing
- Reset values:
  - state = IDLE.
  - All strobes, ac pulses, bus_err and i2s_wait = 0.
  - ar_addr, ar_wrdata, i2s_data, vid_data = 0; ar_be = 2'b11.
- Request sampled in IDLE at edge N: ar_read/ar_write high after edge N.
- ar_ac high at edge M:
  - Strobes low after M.
  - Client ac high for the cycle after M; data valid from the same edge and held until the next capture.
- Minimum request-to-ac latency is 3 cycles (with ar_ac in the first BUSY cycle).
- Back-to-back throughput is one transaction per (bridge latency + 2) cycles.
- Reset mid-BUSY: strobes drop asynchronously, no ac is issued, and the client re-requests.

## Structure
- Package sdram_arb_pkg:
  - enum arb_state_t {IDLE, BUSY, GAP}
  - enum arb_client_t {CL_INIT, CL_I2S, CL_VID}
  - localparam default TIMEOUT_CYC
- Single module; the timeout counter and grant logic are inline.
- No sub-module is needed.

## Test plan
- Loader phase: init_done=0; init_we with addr 0x000010, data 0xBEEF; ar_ac 4 cycles later.
  - Expect ar_write with ar_addr 0x000010, ar_wrdata 0xBEEF, ar_be 11, then one init_ac pulse.
  - i2s_rd asserted at the same time stays waiting, with i2s_wait=1.
- Priority: init_done=1; i2s_rd (addr 0x100000) and vid_rd (0x200000) in the same cycle.
  - I2S is served first, with i2s_data = ar_rddata 0x1234.
  - GAP occurs, then video is served with vid_data 0x5678.
  - init_we is ignored throughout.
- Hold stability: ar_ac delayed 20 cycles; ar_addr and strobes remain constant throughout; vid_ac pulses exactly once.
- Timeout: no ar_ac for 1023 cycles.
  - Strobes drop, bus_err=1, vid_ac pulses with vid_data 0x0000.
  - The next request is served normally and bus_err stays 1.
- Reset mid-BUSY: assert reset 2 cycles into a read.
  - All outputs go to reset values immediately and no ac is issued.
  - After release, a held i2s_rd is re-granted.
- Spurious ar_ac in IDLE: no ac pulse and no data change.
